// File: rtl/fetch_unit.sv
// ============================================================================
//  Module   : fetch_unit
//  Purpose  : Instruction fetch sequencer (IDLE/FETCH/LOAD/EXEC/HALT) with PC.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_unit #(
    parameter logic [7:0] PC_RESET = 8'h00,
    parameter logic [7:0] HALT_OP  = 8'hFF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    output logic       mem_req,
    output logic [7:0] mem_addr,
    input  logic       mem_ready,
    input  logic [7:0] mem_data,
    output logic       ir_load,
    output logic [7:0] ir_data,
    input  logic       exec_done,
    input  logic       branch_en,
    input  logic [7:0] branch_target,
    output logic [7:0] pc,
    output logic       halted
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_EXEC  = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    state_t     state_q;
    logic [7:0] pc_q;
    logic [7:0] ir_data_q;
    logic       mem_req_q;
    logic       ir_load_q;
    logic       halted_q;

    // Outputs are registered alongside the state so each one is a clean Moore
    // signal of the state being entered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            pc_q      <= PC_RESET;
            ir_data_q <= 8'h00;
            mem_req_q <= 1'b0;
            ir_load_q <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (run) begin
                        state_q   <= S_FETCH;
                        mem_req_q <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (mem_ready) begin
                        state_q   <= S_LOAD;
                        ir_data_q <= mem_data;
                        pc_q      <= pc_q + 8'd1;
                        mem_req_q <= 1'b0;
                        ir_load_q <= 1'b1;
                    end
                end
                S_LOAD: begin
                    ir_load_q <= 1'b0;
                    if (ir_data_q == HALT_OP) begin
                        state_q  <= S_HALT;
                        halted_q <= 1'b1;
                    end else begin
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (exec_done) begin
                        if (branch_en) begin
                            pc_q <= branch_target;
                        end
                        if (run) begin
                            state_q   <= S_FETCH;
                            mem_req_q <= 1'b1;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                S_HALT: begin
                    state_q <= S_HALT;
                end
                default: begin
                    state_q   <= S_IDLE;
                    mem_req_q <= 1'b0;
                    ir_load_q <= 1'b0;
                    halted_q  <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req  = mem_req_q;
    assign mem_addr = pc_q;
    assign pc       = pc_q;
    assign ir_load  = ir_load_q;
    assign ir_data  = ir_data_q;
    assign halted   = halted_q;

endmodule

`default_nettype wire

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter PC_RESET, default 8'h00, PC value loaded on reset.
REQ-002 Parameter HALT_OP, default 8'hFF, opcode that stops the fetch unit.
REQ-003 clk  input  1  system clock; all state updates on posedge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 run  input  1  level enable; 1 = fetch/execute cycles proceed.
REQ-006 mem_req  output  1  instruction-memory read request.
REQ-007 mem_addr  output  8  instruction address (= pc).
REQ-008 mem_ready  input  1  memory read data valid this cycle.
REQ-009 mem_data  input  8  instruction byte from memory.
REQ-010 ir_load  output  1  load strobe to the instruction register.
REQ-011 ir_data  output  8  instruction byte presented to the instruction register.
REQ-012 exec_done  input  1  execute stage finished current instruction.
REQ-013 branch_en  input  1  with exec_done, take branch.
REQ-014 branch_target  input  8  next PC when branch taken.
REQ-015 pc  output  8  current program counter.
REQ-016 halted  output  1  1 while in HALT state.

Function
REQ-017 FSM states SHALL be IDLE, FETCH, LOAD, EXEC, HALT; all outputs are Moore or registered.
REQ-018 IDLE: mem_req=0, ir_load=0; run=1 at posedge -> FETCH; else stay.
REQ-019 FETCH: mem_req=1, mem_addr=pc; posedge with mem_ready=1 -> ir_data<=mem_data, pc<=pc+1 mod 256 (8'hFF wraps to 8'h00), go LOAD; mem_ready=0 -> stay, no state change.
REQ-020 LOAD: ir_load=1 for exactly one cycle, ir_data stable; next state HALT if ir_data==HALT_OP, else EXEC.
REQ-021 EXEC: ir_load=0, mem_req=0; wait for exec_done=1; at that posedge pc<=branch_target if branch_en=1 (else pc unchanged), next FETCH if run=1, else IDLE.
REQ-022 HALT: halted=1, mem_req=0, ir_load=0; state, pc, ir_data frozen until reset.
REQ-023 Minimum latency: FETCH entry to ir_load high = 1 cycle after mem_ready sample (mem_ready on first FETCH cycle -> ir_load on next cycle).
REQ-024 run deasserted during FETCH/LOAD/EXEC SHALL NOT abort; current instruction completes, then IDLE.
REQ-025 mem_ready, mem_data, exec_done, branch_en SHALL be ignored outside their consuming state.
REQ-026 ir_data SHALL change only on the FETCH->LOAD transition; mem_data changes at other times have no effect.
REQ-027 branch_en without exec_done SHALL have no effect.

Reset
REQ-028 reset=0 SHALL immediately (asynchronously) force state=IDLE, pc=PC_RESET, ir_data=8'h00, mem_req=0, ir_load=0, halted=0.
REQ-029 Reset asserted mid-FETCH/LOAD/EXEC/HALT SHALL discard the in-flight instruction with no ir_load pulse emitted.
REQ-030 After reset release, no state change until first posedge with run=1.

Verification
REQ-031 Reset, run=1, memory returns 8'hA3 at addr 00 with mem_ready same cycle -> one-cycle ir_load with ir_data=8'hA3, pc=8'h01, then EXEC.
REQ-032 mem_ready held low 3 cycles in FETCH -> mem_req stays 1, mem_addr constant, no ir_load; ready on 4th -> normal load.
REQ-033 In EXEC, exec_done=1, branch_en=1, branch_target=8'h40 -> next FETCH shows mem_addr=8'h40.
REQ-034 pc=8'hFF fetch of 8'h1C -> ir_data=8'h1C, pc wraps to 8'h00.
REQ-035 Fetch of 8'hFF -> ir_load pulse with ir_data=8'hFF, then halted=1, mem_req=0 indefinitely; mem_data/exec_done toggling ignored.
REQ-036 reset driven low between clock edges during EXEC -> outputs return to reset values without waiting for posedge; run=0 mid-EXEC -> IDLE after exec_done.
